// File: rtl/stride_burst_read_master_if.sv
// Avalon-MM read-master bus bundle used between the strided burst read master
// and the SDRAM controller slave port.
interface stride_burst_read_master_if #(
   parameter int DATAWIDTH       = 32,
   parameter int BYTEENABLEWIDTH = 4,
   parameter int ADDRESSWIDTH    = 32,
   parameter int BURSTCOUNTWIDTH = 4
);
   logic [ADDRESSWIDTH-1:0]    master_address;
   logic                       master_read;
   logic [BYTEENABLEWIDTH-1:0] master_byteenable;
   logic [BURSTCOUNTWIDTH-1:0] master_burstcount;
   logic [DATAWIDTH-1:0]       master_readdata;
   logic                       master_readdatavalid;
   logic                       master_waitrequest;

   modport master (
      output master_address, master_read, master_byteenable, master_burstcount,
      input  master_readdata, master_readdatavalid, master_waitrequest
   );

   modport slave (
      input  master_address, master_read, master_byteenable, master_burstcount,
      output master_readdata, master_readdatavalid, master_waitrequest
   );
endinterface

// File: rtl/stride_burst_read_master.sv
// Avalon-MM read master: contiguous burst reads (stride 1) or strided single-word
// reads, buffering returned data in a show-ahead FIFO popped by user logic.
module stride_burst_read_master #(
   parameter int DATAWIDTH       = 32,
   parameter int BYTEENABLEWIDTH = 4,
   parameter int ADDRESSWIDTH    = 32,
   parameter int MAXBURSTCOUNT   = 8,
   parameter int BURSTCOUNTWIDTH = 4,
   parameter int FIFODEPTH       = 64,
   parameter int FIFODEPTH_LOG2  = 6,
   parameter int STRIDEWIDTH     = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDRESSWIDTH-1:0] control_read_base,
   input  logic [ADDRESSWIDTH-1:0] control_read_length,
   input  logic [STRIDEWIDTH-1:0]  control_stride,
   input  logic                    control_go,
   input  logic                    control_stop,
   output logic                    control_busy,
   output logic                    control_done,
   output logic                    control_early_done,
   output logic                    control_aborted,
   input  logic                    user_read_buffer,
   output logic [DATAWIDTH-1:0]    user_buffer_data,
   output logic                    user_data_available,
   stride_burst_read_master_if.master avm
);
   localparam int BE_LOG2 = $clog2(BYTEENABLEWIDTH);
   localparam int CW      = FIFODEPTH_LOG2 + 1;
   localparam int SW      = FIFODEPTH_LOG2 + 2;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
   typedef logic [FIFODEPTH_LOG2-1:0] ptr_t;

   state_e                     state_q, state_d;
   logic [ADDRESSWIDTH-1:0]    address_q, address_d;
   logic [ADDRESSWIDTH-1:0]    words_left_q, words_left_d;
   logic [STRIDEWIDTH-1:0]     stride_q, stride_d;
   logic                       read_q, read_d;
   logic [BURSTCOUNTWIDTH-1:0] burst_q, burst_d;
   logic [CW-1:0]              pending_q, pending_d;
   logic [CW-1:0]              count_q, count_d;
   ptr_t                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                       aborted_q, aborted_d;
   logic                       stop_req_q, stop_req_d;
   logic [DATAWIDTH-1:0]       mem_q [FIFODEPTH];

   logic                       accept, push, pop;
   logic [BURSTCOUNTWIDTH-1:0] burst_next;
   logic [SW-1:0]              gate_sum;

   function automatic logic [BURSTCOUNTWIDTH-1:0] burst_of(
      input logic [ADDRESSWIDTH-1:0] addr,
      input logic [ADDRESSWIDTH-1:0] wl,
      input logic [STRIDEWIDTH-1:0]  st
   );
      logic [ADDRESSWIDTH-1:0] off, room;
      off  = (addr >> BE_LOG2) & ADDRESSWIDTH'(MAXBURSTCOUNT - 1);
      room = ADDRESSWIDTH'(MAXBURSTCOUNT) - off;
      if (st != STRIDEWIDTH'(1)) return BURSTCOUNTWIDTH'(1);
      return (wl < room) ? BURSTCOUNTWIDTH'(wl) : BURSTCOUNTWIDTH'(room);
   endfunction

   always_comb begin
      state_d      = state_q;
      address_d    = address_q;
      words_left_d = words_left_q;
      stride_d     = stride_q;
      read_d       = read_q;
      burst_d      = burst_q;
      aborted_d    = aborted_q;
      stop_req_d   = stop_req_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      burst_next   = '0;
      gate_sum     = '0;

      accept = read_q & ~avm.master_waitrequest;
      push   = avm.master_readdatavalid & (state_q != IDLE);
      pop    = user_read_buffer & (count_q != '0);

      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d   = count_q + CW'(push) - CW'(pop);
      pending_d = pending_q + (accept ? CW'(burst_q) : CW'(0)) - CW'(push);

      if (accept) begin
         read_d       = 1'b0;
         words_left_d = words_left_q - ADDRESSWIDTH'(burst_q);
         if (stride_q == STRIDEWIDTH'(1))
            address_d = address_q + (ADDRESSWIDTH'(burst_q) << BE_LOG2);
         else
            address_d = address_q + (ADDRESSWIDTH'(stride_q) << BE_LOG2);
      end

      case (state_q)
         IDLE: begin
            if (control_go) begin
               address_d    = control_read_base;
               words_left_d = control_read_length >> BE_LOG2;
               stride_d     = control_stride;
               aborted_d    = 1'b0;
               if (words_left_d != '0) state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (control_stop) begin
               stop_req_d = 1'b1;
               aborted_d  = 1'b1;
            end
            if (accept && words_left_d == '0)   state_d = DRAIN;
            else if (stop_req_q && !read_q)     state_d = DRAIN;
         end
         DRAIN: begin
            if (control_stop) aborted_d = 1'b1;
            if (pending_q == '0) begin
               state_d    = IDLE;
               stop_req_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Next command is chosen from post-update counters so bursts can go back-to-back
      // while the FIFO-space gate still accounts for everything already in flight.
      if (state_d == ISSUE && !read_d) begin
         burst_next = burst_of(address_d, words_left_d, stride_d);
         gate_sum   = SW'(pending_d) + SW'(count_d) + SW'(burst_next);
         if (words_left_d != '0 && !stop_req_d && gate_sum <= SW'(FIFODEPTH)) begin
            read_d  = 1'b1;
            burst_d = burst_next;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         address_q    <= '0;
         words_left_q <= '0;
         stride_q     <= '0;
         read_q       <= 1'b0;
         burst_q      <= '0;
         pending_q    <= '0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         aborted_q    <= 1'b0;
         stop_req_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         address_q    <= address_d;
         words_left_q <= words_left_d;
         stride_q     <= stride_d;
         read_q       <= read_d;
         burst_q      <= burst_d;
         pending_q    <= pending_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         aborted_q    <= aborted_d;
         stop_req_q   <= stop_req_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= avm.master_readdata;
   end

   assign avm.master_address    = address_q;
   assign avm.master_read       = read_q;
   assign avm.master_byteenable = '1;
   assign avm.master_burstcount = burst_q;

   assign control_busy        = (state_q != IDLE);
   assign control_done        = (state_q == IDLE);
   assign control_early_done  = (words_left_q == '0) | stop_req_q;
   assign control_aborted     = aborted_q;
   assign user_data_available = (count_q != '0);
   assign user_buffer_data    = mem_q[rd_ptr_q];
endmodule

// File: doc/stride_burst_read_master.md
Name: stride_burst_read_master

Overview:
- Parametrised successor to the single-mode bursting read master.
- Accepts a word-aligned base address, a byte length and a word stride, then posts Avalon-MM read bursts. Stride 1 gives contiguous burst reads; any other stride gives strided single-word reads.
- Read data is buffered in an internal show-ahead FIFO that user logic pops. A stop request halts posting, drains outstanding reads and returns to idle.
- Sits between DMA/user control logic and the SDRAM controller's Avalon-MM slave.

Parameters:
- DATAWIDTH, 32, data bus width in bits.
- BYTEENABLEWIDTH, 4, bytes per word (DATAWIDTH/8). Power of two.
- ADDRESSWIDTH, 32, byte address and length width.
- MAXBURSTCOUNT, 8, largest burst in words. Power of two, ≥1.
- BURSTCOUNTWIDTH, 4, width of master_burstcount. Must satisfy log2(MAXBURSTCOUNT)+1.
- FIFODEPTH, 64, internal FIFO words. Power of two, ≥2*MAXBURSTCOUNT.
- FIFODEPTH_LOG2, 6, log2(FIFODEPTH).
- STRIDEWIDTH, 16, width of control_stride.

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- control_read_base  in  ADDRESSWIDTH  word-aligned byte start address
- control_read_length  in  ADDRESSWIDTH  byte length; low log2(BYTEENABLEWIDTH) bits ignored
- control_stride  in  STRIDEWIDTH  address step in words; 0 = fixed location, 1 = contiguous
- control_go  in  1  one-cycle start pulse
- control_stop  in  1  one-cycle abort pulse
- control_busy  out  1  high whenever state≠IDLE
- control_done  out  1  high in IDLE
- control_early_done  out  1  no words left to post
- control_aborted  out  1  last transfer ended by stop; sticky until next accepted go
- user_read_buffer  in  1  pop FIFO head
- user_buffer_data  out  DATAWIDTH  FIFO head (show-ahead)
- user_data_available  out  1  FIFO not empty
- master_address  out  ADDRESSWIDTH  byte address
- master_read  out  1  read request
- master_byteenable  out  BYTEENABLEWIDTH  all ones
- master_burstcount  out  BURSTCOUNTWIDTH  words in burst
- master_readdata  in  DATAWIDTH  returned data
- master_readdatavalid  in  1  data valid
- master_waitrequest  in  1  slave stall

Behaviour:
- Reset (reset_n=0, async):
  - State goes to IDLE.
  - address, words_left, reads_pending, FIFO pointers/count, control_aborted and stop_req all clear to 0.
  - Outputs: master_read=0, control_busy=0, control_done=1, control_early_done=1, user_data_available=0.
  - Reset mid-transfer discards all state and FIFO contents. In-flight readdatavalid after reset release while IDLE is ignored (not written).
- State machine:
  - IDLE: control_go=1 latches base, words_left=length/BYTEENABLEWIDTH and stride, clears control_aborted.
    - If words_left≠0, go to ISSUE; if zero, stay in IDLE.
    - control_stop in IDLE is ignored.
  - ISSUE: posts commands.
    - Go to DRAIN when words_left reaches 0 on an accepted command.
    - Go to DRAIN when stop_req=1 and master_read=0 (no command held).
  - DRAIN: go to IDLE when reads_pending=0.
  - control_go outside IDLE is ignored.
- Burst count:
  - Contiguous mode (stride=1): off=(address/BYTEENABLEWIDTH)&(MAXBURSTCOUNT-1); burst=min(MAXBURSTCOUNT-off, words_left). Bursts therefore never cross a MAXBURSTCOUNT-word boundary.
  - Strided or fixed mode (stride≠1): burst=1.
- Issue gate: master_read=1 in ISSUE when words_left≠0, !stop_req and reads_pending+fifo_count+burst ≤ FIFODEPTH. The sum is computed FIFODEPTH_LOG2+2 bits wide. Data returns therefore never overflow the FIFO.
- Accept = master_read & !master_waitrequest. On accept:
  - words_left -= burst.
  - address += burst*BYTEENABLEWIDTH when stride=1; += stride*BYTEENABLEWIDTH otherwise; unchanged when stride=0. Address wraps modulo 2^ADDRESSWIDTH.
- Avalon hold rule: address and burstcount are stable while master_read&master_waitrequest.
- Stop:
  - control_stop in ISSUE or DRAIN sets stop_req and control_aborted.
  - If a command is held under waitrequest, master_read stays high until it is accepted. No further commands are posted after that.
  - stop_req clears on entry to IDLE.
- reads_pending (FIFODEPTH_LOG2+1 bits): += burst on accept, −1 per readdatavalid. Both in the same cycle give +burst−1.
- FIFO:
  - Push on readdatavalid when state≠IDLE.
  - Pop on user_read_buffer & !empty; pop while empty is ignored.
  - Simultaneous push and pop keeps the count unchanged. Full is unreachable by construction.
  - Data is visible on user_buffer_data the cycle after the push.
- control_early_done = (words_left==0) | stop_req.
- FIFO contents survive the return to IDLE and remain poppable. A new go does not flush the FIFO.

Test Plan:
- Reset pulse mid-ISSUE with 3 words pending → all outputs at reset values, FIFO empty, done=1 next edge.
- Base=0x100, length=64, stride=1, no waitrequest → bursts of 8,8 at 0x100, 0x120; 16 words popped in order; done after last return.
- Base=0x10C, length=40, stride=1 → bursts 5@0x10C, 5@0x120; no burst crosses an 8-word boundary.
- Base=0x200, length=16, stride=3 → four single reads at 0x200, 0x20C, 0x218, 0x224. Repeat with stride=0 → four reads at 0x200.
- Length=4096 with user never popping → posting stalls once pending+used reaches 64; no data lost; posting resumes as pops occur.
- Stop while master_read held under waitrequest for 5 cycles → command completes, no more commands, FIFO receives exactly the pending words, aborted=1, done=1.
